// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch.
// Segment patterns are consumed only when HEX_OUT_EN is defined.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_e;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] UNITS_MAX = 4'd9;
    localparam logic [BCD_W-1:0] TENS_MAX  = 4'd5;

    // Active-low segments, bit order g..a
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // True when a digit sits at (or, defensively, beyond) its roll-over limit
    function automatic logic bcd_last(input logic [BCD_W-1:0] d, input logic [BCD_W-1:0] lim);
        return (d >= lim);
    endfunction

    // Next value of a BCD digit; anything at or past the limit wraps to zero
    function automatic logic [BCD_W-1:0] bcd_next(input logic [BCD_W-1:0] d, input logic [BCD_W-1:0] lim);
        logic [BCD_W-1:0] n;
        if (d >= lim) begin
            n = 4'd0;
        end else begin
            n = d + 4'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_if.sv
// Button/tick inputs and display outputs of the stopwatch.
// HEX0..HEX3 exist only when HEX_OUT_EN is defined.
interface stopwatch_bcd_if;

    logic                           TICK;
    logic                           SSn;
    logic                           CLRn;
    logic [stopwatch_pkg::BCD_W-1:0] SEC_U;
    logic [stopwatch_pkg::BCD_W-1:0] SEC_T;
    logic [stopwatch_pkg::BCD_W-1:0] MIN_U;
    logic [stopwatch_pkg::BCD_W-1:0] MIN_T;
    logic                           RUNNING;
    logic                           SEC_TC;
    logic                           WRAP;

`ifdef HEX_OUT_EN
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;

    modport master (
        output TICK, SSn, CLRn,
        input  SEC_U, SEC_T, MIN_U, MIN_T, RUNNING, SEC_TC, WRAP,
        input  HEX0, HEX1, HEX2, HEX3
    );

    modport slave (
        input  TICK, SSn, CLRn,
        output SEC_U, SEC_T, MIN_U, MIN_T, RUNNING, SEC_TC, WRAP,
        output HEX0, HEX1, HEX2, HEX3
    );
`else
    modport master (
        output TICK, SSn, CLRn,
        input  SEC_U, SEC_T, MIN_U, MIN_T, RUNNING, SEC_TC, WRAP
    );

    modport slave (
        input  TICK, SSn, CLRn,
        output SEC_U, SEC_T, MIN_U, MIN_T, RUNNING, SEC_TC, WRAP
    );
`endif

endinterface

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low 7-segment pattern (g..a); non-BCD inputs blank the display.
module bcd_to_7seg
    import stopwatch_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    // Digit lookup
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch clocked by the prescaler tick, with start/stop and clear buttons.
// Optional HEX_OUT_EN adds four 7-segment decoders driven from the digit registers.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 4,
    parameter int SUBW          = 3
) (
    input logic            CLK,
    input logic            RSTn,
    stopwatch_bcd_if.slave sw
);

    localparam logic [SUBW-1:0] SUB_MAX  = SUBW'(TICKS_PER_SEC - 1);
    localparam logic [SUBW-1:0] SUB_ZERO = SUBW'(0);
    localparam logic [SUBW-1:0] SUB_ONE  = SUBW'(1);

    logic             ss_sync1_r, ss_sync2_r, ss_hist_r;
    logic             clr_sync1_r, clr_sync2_r, clr_hist_r;
    logic             ss_evt_s, clr_evt_s;
    logic             tick_s;
    state_e           state_r;
    logic             running_r;
    logic [SUBW-1:0]  sub_r;
    logic [BCD_W-1:0] sec_u_r, sec_t_r, min_u_r, min_t_r;
    logic             sec_tc_r, wrap_r;
    logic             sub_last_s, su_c_s, st_c_s, mu_c_s, mt_c_s;

    // Two-flop synchronisers plus a history flop per button, idle high
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ss_sync1_r  <= 1'b1;
            ss_sync2_r  <= 1'b1;
            ss_hist_r   <= 1'b1;
            clr_sync1_r <= 1'b1;
            clr_sync2_r <= 1'b1;
            clr_hist_r  <= 1'b1;
        end else begin
            ss_sync1_r  <= sw.SSn;
            ss_sync2_r  <= ss_sync1_r;
            ss_hist_r   <= ss_sync2_r;
            clr_sync1_r <= sw.CLRn;
            clr_sync2_r <= clr_sync1_r;
            clr_hist_r  <= clr_sync2_r;
        end
    end

    assign ss_evt_s  = ~ss_sync2_r & ss_hist_r;
    assign clr_evt_s = ~clr_sync2_r & clr_hist_r;
    assign tick_s    = sw.TICK;

    // Carry chain is fully combinational so a 59:59 roll resolves in one edge
    assign sub_last_s = (sub_r == SUB_MAX);
    assign su_c_s     = bcd_last(sec_u_r, UNITS_MAX);
    assign st_c_s     = su_c_s & bcd_last(sec_t_r, TENS_MAX);
    assign mu_c_s     = st_c_s & bcd_last(min_u_r, UNITS_MAX);
    assign mt_c_s     = mu_c_s & bcd_last(min_t_r, TENS_MAX);

    // Run/pause/clear FSM together with the sub-second counter and digits it gates
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r   <= IDLE;
            running_r <= 1'b0;
            sub_r     <= SUB_ZERO;
            sec_u_r   <= 4'd0;
            sec_t_r   <= 4'd0;
            min_u_r   <= 4'd0;
            min_t_r   <= 4'd0;
            sec_tc_r  <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            sec_tc_r <= 1'b0;
            wrap_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ss_evt_s) begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        running_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (ss_evt_s) begin
                        state_r   <= PAUSE;
                        running_r <= 1'b0;
                    end else begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end
                    // Gated on the current state, so the tick on the leaving edge still counts
                    if (tick_s) begin
                        if (sub_last_s) begin
                            sub_r    <= SUB_ZERO;
                            sec_u_r  <= bcd_next(sec_u_r, UNITS_MAX);
                            sec_t_r  <= su_c_s ? bcd_next(sec_t_r, TENS_MAX)  : sec_t_r;
                            min_u_r  <= st_c_s ? bcd_next(min_u_r, UNITS_MAX) : min_u_r;
                            min_t_r  <= mu_c_s ? bcd_next(min_t_r, TENS_MAX)  : min_t_r;
                            sec_tc_r <= 1'b1;
                            wrap_r   <= mt_c_s;
                        end else begin
                            sub_r <= sub_r + SUB_ONE;
                        end
                    end else begin
                        sub_r <= sub_r;
                    end
                end
                PAUSE: begin
                    if (clr_evt_s) begin
                        state_r   <= IDLE;
                        running_r <= 1'b0;
                        sub_r     <= SUB_ZERO;
                        sec_u_r   <= 4'd0;
                        sec_t_r   <= 4'd0;
                        min_u_r   <= 4'd0;
                        min_t_r   <= 4'd0;
                    end else if (ss_evt_s) begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end else begin
                        state_r   <= PAUSE;
                        running_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    running_r <= 1'b0;
                    sub_r     <= SUB_ZERO;
                    sec_u_r   <= 4'd0;
                    sec_t_r   <= 4'd0;
                    min_u_r   <= 4'd0;
                    min_t_r   <= 4'd0;
                end
            endcase
        end
    end

    assign sw.SEC_U   = sec_u_r;
    assign sw.SEC_T   = sec_t_r;
    assign sw.MIN_U   = min_u_r;
    assign sw.MIN_T   = min_t_r;
    assign sw.RUNNING = running_r;
    assign sw.SEC_TC  = sec_tc_r;
    assign sw.WRAP    = wrap_r;

`ifdef HEX_OUT_EN
    bcd_to_7seg u_hex0 (.bcd(sec_u_r), .seg(sw.HEX0));
    bcd_to_7seg u_hex1 (.bcd(sec_t_r), .seg(sw.HEX1));
    bcd_to_7seg u_hex2 (.bcd(min_u_r), .seg(sw.HEX2));
    bcd_to_7seg u_hex3 (.bcd(min_t_r), .seg(sw.HEX3));
`endif

endmodule
